pipe_stage_skid: RTL and testbench
==================================

# pipe_stage_skid

Parametrised pipeline-stage register with valid/ready handshake, a two-entry skid buffer, synchronous flush, and bubble control masking. It is the generic replacement for the fixed per-stage write-enabled registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an opaque datapath payload plus a control field, and lets a stage stall without a combinational ready path crossing it. A saturating stall counter supports performance analysis.

## Interface
Parameters:
- DATA_W, 256, payload width in bits (default = PC + two operands + immediate, 4×64)
- CTRL_W, 16, control-field width in bits (decoded opcode/control signals)
- STALL_W, 16, width of the stall counter

Ports:
- clock  input  1  single clock; all state updates on posedge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  upstream has a valid entry
- in_ready  output  1  stage can accept an entry this cycle
- in_data  input  DATA_W  upstream payload
- in_ctrl  input  CTRL_W  upstream control field
- flush  input  1  discard all held entries (branch mispredict / exception)
- out_valid  output  1  stage presents a valid entry
- out_ready  input  1  downstream accepts the entry this cycle
- out_data  output  DATA_W  payload of the head entry
- out_ctrl  output  CTRL_W  control of the head entry; forced to 0 when out_valid=0
- occupancy  output  2  number of held entries (0, 1 or 2)
- stall_cnt  output  STALL_W  cycles with out_valid=1 and out_ready=0, saturating

## Operation
- Storage: main register (drives outputs) and skid register, each with payload, ctrl and a valid bit.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = (occupancy != 2). It is a pure function of registered state, with no combinational path from out_ready.
- out_valid = main valid; out_data = main payload; out_ctrl = main valid ? main ctrl : 0 (bubbles are NOPs).
- States and transitions, evaluated when flush=0:
  - EMPTY (0): in_fire → main←in, ONE. No in_fire → stay in EMPTY.
  - ONE (1): in_fire & out_fire → main←in, stay in ONE. in_fire only → skid←in, FULL. out_fire only → EMPTY. Neither → hold.
  - FULL (2): in_ready=0. out_fire → main←skid, skid invalid, ONE. No out_fire → hold.
- Flush (flush=1): both valid bits cleared next cycle, giving occupancy 0. Any in_fire in the same cycle is discarded. Any out_fire in the same cycle still counts downstream, because the downstream stage sampled it. Payload/ctrl registers hold their old contents; ctrl is masked by valid on output.
- Reset: valid bits, payload, ctrl and stall_cnt all go to 0. Reset dominates flush.
- stall_cnt: +1 in each cycle with out_valid & !out_ready. It holds at 2^STALL_W−1 (saturating, with no wrap). It is cleared only by reset, not by flush.
- Payload and ctrl are passed through unmodified, with no width conversion.

## Timing
- Reset values: out_valid=0, out_data=0, out_ctrl=0, occupancy=0, in_ready=1, stall_cnt=0.
- Latency: in_fire in cycle N appears on outputs in cycle N+1 when the stage was EMPTY, or when it was ONE with out_fire in cycle N.
- Throughput: 1 entry/cycle sustained when out_ready is held at 1.
- Back-pressure: in_ready falls one cycle after the skid register fills. The skid register absorbs the one entry accepted in the cycle out_ready dropped.
- in_ready rises in the cycle after the first out_fire from FULL.
- Ordering: entries leave in acceptance order. No entry is ever duplicated or lost except by flush.
- All outputs are registered or derived from registered state only. out_ctrl masking is the only output gate.

## Test plan
- Reset mid-stream: load two entries until FULL, then assert reset for 1 cycle. Required: next cycle out_valid=0, out_data=0, occupancy=0, in_ready=1, stall_cnt=0.
- Streaming: with out_ready=1, drive data 0x1,0x2,0x3 on consecutive cycles. Required: out_data 0x1,0x2,0x3 on consecutive cycles starting one cycle later; occupancy stays 1; stall_cnt stays 0.
- Back-pressure: stream 0xA,0xB,0xC with out_ready=0 from cycle 1. Required: 0xA held on the output, 0xB in skid, occupancy=2, in_ready=0. 0xC must be held upstream and not accepted. After releasing out_ready: 0xA,0xB,0xC emitted in order; stall_cnt equals the number of stalled cycles.
- Flush with simultaneous input: in FULL state, assert flush and in_valid (data 0xD) together. Required: next cycle occupancy=0, out_valid=0, out_ctrl=0; 0xD never appears.
- Bubble masking: load ctrl=0xFFFF, consume it, then idle. Required: out_ctrl=0 while out_valid=0, even though the ctrl register still holds 0xFFFF.
- Counter saturation: use STALL_W=4 and stall for 20 cycles. Required: stall_cnt reaches 15 and holds at 15.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
//   Generic pipeline-stage register with a valid/ready handshake and a
//   two-entry skid buffer. It replaces fixed write-enabled stage registers.
//   in_ready depends only on registered state, so no combinational ready
//   path crosses the stage. Flush drops every held entry. The control field
//   is masked to zero whenever no valid entry is presented, so a bubble
//   reads downstream as a NOP. A saturating counter records stalled cycles.
//
// Ports
//   clock      : single clock, all state updates on posedge
//   reset      : synchronous active-high reset (dominates flush)
//   in_valid   : upstream has a valid entry
//   in_ready   : stage can accept an entry this cycle
//   in_data    : upstream payload [DATA_W]
//   in_ctrl    : upstream control field [CTRL_W]
//   flush      : discard all held entries
//   out_valid  : head entry is valid
//   out_ready  : downstream accepts the head entry this cycle
//   out_data   : payload of the head entry [DATA_W]
//   out_ctrl   : control of the head entry, 0 when out_valid=0 [CTRL_W]
//   occupancy  : number of held entries (0..2)
//   stall_cnt  : cycles with out_valid & !out_ready, saturating [STALL_W]
//
// State table
//   state    | meaning
//   ST_EMPTY | nothing held; main and skid invalid
//   ST_ONE   | main holds the head entry; skid empty
//   ST_FULL  | main holds the head entry; skid holds the next; in_ready=0

module pipe_stage_skid #(
  parameter int DATA_W  = 256,
  parameter int CTRL_W  = 16,
  parameter int STALL_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [1:0]         occupancy,
  output logic [STALL_W-1:0] stall_cnt
);

  // The state encoding equals the entry count, so occupancy is the state.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   main_data_q, skid_data_q;
  logic [CTRL_W-1:0]   main_ctrl_q, skid_ctrl_q;
  logic                load_main_in, load_main_skid, load_skid;
  logic                in_fire, out_fire;

  localparam logic [STALL_W-1:0] STALL_MAX = {STALL_W{1'b1}};
  localparam logic [STALL_W-1:0] STALL_ONE = {{(STALL_W-1){1'b0}}, 1'b1};

  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_data_q;
  assign out_ctrl  = out_valid ? main_ctrl_q : '0;
  assign occupancy = state_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      // Entries are dropped. The payload registers keep their contents,
      // and out_ctrl masking hides the stale control.
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            load_main_in = 1'b1;
            state_d      = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire) begin
            load_skid = 1'b1;
            state_d   = ST_FULL;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            load_main_skid = 1'b1;
            state_d        = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      if (load_main_in) begin
        main_data_q <= in_data;
        main_ctrl_q <= in_ctrl;
      end else if (load_main_skid) begin
        main_data_q <= skid_data_q;
        main_ctrl_q <= skid_ctrl_q;
      end
      if (load_skid) begin
        skid_data_q <= in_data;
        skid_ctrl_q <= in_ctrl;
      end
    end
  end

  // Flush does not clear the counter; only reset clears it.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != STALL_MAX)) begin
      stall_cnt <= stall_cnt + STALL_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

  localparam int DATA_W  = 32;
  localparam int CTRL_W  = 16;
  localparam int STALL_W = 4;
  localparam int NV      = 25;

  logic               clock = 1'b0;
  logic               reset, in_valid, in_ready, flush, out_valid, out_ready;
  logic [DATA_W-1:0]  in_data, out_data;
  logic [CTRL_W-1:0]  in_ctrl, out_ctrl;
  logic [1:0]         occupancy;
  logic [STALL_W-1:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .STALL_W(STALL_W)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst, iv;
    logic [31:0] id;
    logic [15:0] ic;
    logic        fl, ordy;
    logic        e_ov;
    logic [31:0] e_od;
    logic [15:0] e_oc;
    logic [1:0]  e_occ;
    logic        e_irdy;
    logic [3:0]  e_sc;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(logic rst, logic iv, logic [31:0] id, logic [15:0] ic,
                              logic fl, logic ordy, logic e_ov, logic [31:0] e_od,
                              logic [15:0] e_oc, logic [1:0] e_occ, logic e_irdy,
                              logic [3:0] e_sc);
    vec_t v;
    v.rst = rst; v.iv = iv; v.id = id; v.ic = ic; v.fl = fl; v.ordy = ordy;
    v.e_ov = e_ov; v.e_od = e_od; v.e_oc = e_oc; v.e_occ = e_occ;
    v.e_irdy = e_irdy; v.e_sc = e_sc;
    return v;
  endfunction

  task automatic chk(input string name, input int step, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, step, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    //              rst iv  id     ic      fl ordy | ov od     oc      occ irdy sc
    // reset
    vecs[0]  = mk(1, 0, 32'h0,  16'h0,    0, 0,    0, 32'h0,  16'h0,    0, 1, 0);
    // streaming 1,2,3 with out_ready=1
    vecs[1]  = mk(0, 1, 32'h1,  16'h11,   0, 1,    1, 32'h1,  16'h11,   1, 1, 0);
    vecs[2]  = mk(0, 1, 32'h2,  16'h12,   0, 1,    1, 32'h2,  16'h12,   1, 1, 0);
    vecs[3]  = mk(0, 1, 32'h3,  16'h13,   0, 1,    1, 32'h3,  16'h13,   1, 1, 0);
    vecs[4]  = mk(0, 0, 32'h0,  16'h0,    0, 1,    0, 32'h3,  16'h0,    0, 1, 0);
    // back-pressure: A accepted, B into skid, C held upstream for two cycles
    vecs[5]  = mk(0, 1, 32'hA,  16'hA,    0, 1,    1, 32'hA,  16'hA,    1, 1, 0);
    vecs[6]  = mk(0, 1, 32'hB,  16'hB,    0, 0,    1, 32'hA,  16'hA,    2, 0, 1);
    vecs[7]  = mk(0, 1, 32'hC,  16'hC,    0, 0,    1, 32'hA,  16'hA,    2, 0, 2);
    vecs[8]  = mk(0, 1, 32'hC,  16'hC,    0, 0,    1, 32'hA,  16'hA,    2, 0, 3);
    vecs[9]  = mk(0, 1, 32'hC,  16'hC,    0, 1,    1, 32'hB,  16'hB,    1, 1, 3);
    vecs[10] = mk(0, 1, 32'hC,  16'hC,    0, 1,    1, 32'hC,  16'hC,    1, 1, 3);
    vecs[11] = mk(0, 0, 32'h0,  16'h0,    0, 1,    0, 32'hC,  16'h0,    0, 1, 3);
    // flush in FULL with simultaneous 0xD input
    vecs[12] = mk(0, 1, 32'h21, 16'h21,   0, 0,    1, 32'h21, 16'h21,   1, 1, 3);
    vecs[13] = mk(0, 1, 32'h22, 16'h22,   0, 0,    1, 32'h21, 16'h21,   2, 0, 4);
    vecs[14] = mk(0, 1, 32'hD,  16'hD,    1, 0,    0, 32'h21, 16'h0,    0, 1, 5);
    vecs[15] = mk(0, 0, 32'h0,  16'h0,    0, 0,    0, 32'h21, 16'h0,    0, 1, 5);
    vecs[16] = mk(0, 1, 32'h31, 16'h31,   0, 1,    1, 32'h31, 16'h31,   1, 1, 5);
    vecs[17] = mk(0, 0, 32'h0,  16'h0,    0, 1,    0, 32'h31, 16'h0,    0, 1, 5);
    // bubble masking with ctrl 0xFFFF
    vecs[18] = mk(0, 1, 32'h41, 16'hFFFF, 0, 1,    1, 32'h41, 16'hFFFF, 1, 1, 5);
    vecs[19] = mk(0, 0, 32'h0,  16'h0,    0, 1,    0, 32'h41, 16'h0,    0, 1, 5);
    vecs[20] = mk(0, 0, 32'h0,  16'h0,    0, 0,    0, 32'h41, 16'h0,    0, 1, 5);
    // reset mid-stream from FULL; flush and in_valid also asserted
    vecs[21] = mk(0, 1, 32'h51, 16'h51,   0, 0,    1, 32'h51, 16'h51,   1, 1, 5);
    vecs[22] = mk(0, 1, 32'h52, 16'h52,   0, 0,    1, 32'h51, 16'h51,   2, 0, 6);
    vecs[23] = mk(1, 1, 32'h53, 16'h53,   1, 0,    0, 32'h0,  16'h0,    0, 1, 0);
    vecs[24] = mk(0, 0, 32'h0,  16'h0,    0, 0,    0, 32'h0,  16'h0,    0, 1, 0);

    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
    flush = 1'b0; out_ready = 1'b0;
    #2;

    for (int i = 0; i < NV; i++) begin
      reset     = vecs[i].rst;
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].id;
      in_ctrl   = vecs[i].ic;
      flush     = vecs[i].fl;
      out_ready = vecs[i].ordy;
      tick();
      chk("out_valid", i, 32'(out_valid), 32'(vecs[i].e_ov));
      chk("out_data",  i, out_data,       vecs[i].e_od);
      chk("out_ctrl",  i, 32'(out_ctrl),  32'(vecs[i].e_oc));
      chk("occupancy", i, 32'(occupancy), 32'(vecs[i].e_occ));
      chk("in_ready",  i, 32'(in_ready),  32'(vecs[i].e_irdy));
      chk("stall_cnt", i, 32'(stall_cnt), 32'(vecs[i].e_sc));
    end

    // Counter saturation: one entry held with out_ready=0 for 20 cycles.
    reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h61; in_ctrl = 16'h61;
    tick();
    in_valid = 1'b0;
    chk("sat_load_occ", 100, 32'(occupancy), 32'd1);
    chk("sat_load_cnt", 100, 32'(stall_cnt), 32'd0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("sat_cnt",  100 + k, 32'(stall_cnt), (k > 15) ? 32'd15 : 32'(k));
      chk("sat_hold", 100 + k, out_data, 32'h61);
    end
    // Flush must not clear the counter.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_occ", 130, 32'(occupancy), 32'd0);
    chk("flush_cnt", 130, 32'(stall_cnt), 32'd15);
    tick();
    chk("idle_cnt",  131, 32'(stall_cnt), 32'd15);
    chk("idle_ctrl", 131, 32'(out_ctrl),  32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
